// File: rtl/multibank_memory_rr.sv
// Banked multiport RAM with per-bank round-robin arbitration.
// Each bank takes one read and one write per cycle; losing ports stall via
// valid/ready, reads return one cycle after acceptance, and a saturating
// counter tallies rejected requests.

// Round-robin arbiter: priority starts at the pointer and wraps modulo N.
module multibank_memory_rr_arb #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;

    // Pick the first requester at or after the pointer and advance past it.
    always_comb begin : pick
        logic          found;
        logic [PW:0]   cand;
        // NOTE: every output gets a default first so no path can infer a latch.
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(N))
                cand = cand - (PW+1)'(N);
            if (!found && req[cand[PW-1:0]]) begin
                found               = 1'b1;
                gnt[cand[PW-1:0]]   = 1'b1;
                ptr_nxt             = (cand[PW-1:0] == PW'(N-1)) ? '0 : cand[PW-1:0] + 1'b1;
            end
        end
    end

    // Pointer register; holds when nothing is granted.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) ptr <= '0;
        else      ptr <= ptr_nxt;
    end
endmodule

module multibank_memory_rr #(
    parameter int READ_PORTS  = 3,
    parameter int WRITE_PORTS = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int BANKS       = 4,
    parameter int INTERLEAVE  = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]  r_addr,
    input  logic [READ_PORTS-1:0]                  r_avalid,
    output logic [READ_PORTS-1:0]                  r_aready,
    output logic [READ_PORTS-1:0]                  r_dvalid,
    output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  r_data,
    input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] w_addr,
    input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] w_data,
    input  logic [WRITE_PORTS-1:0]                 w_valid,
    output logic [WRITE_PORTS-1:0]                 w_ready,
    output logic [CNT_WIDTH-1:0]                   conflict_cnt,
    input  logic                                   cnt_clr
);
    localparam int BSEL      = $clog2(BANKS);
    localparam int ROW_WIDTH = ADDR_WIDTH - BSEL;
    localparam int ROWS      = 1 << ROW_WIDTH;

    function automatic logic [BSEL-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
        if (INTERLEAVE != 0) return a[BSEL-1:0];
        else                 return a[ADDR_WIDTH-1:ROW_WIDTH];
    endfunction

    function automatic logic [ROW_WIDTH-1:0] row_of(input logic [ADDR_WIDTH-1:0] a);
        if (INTERLEAVE != 0) return a[ADDR_WIDTH-1:BSEL];
        else                 return a[ROW_WIDTH-1:0];
    endfunction

    logic [READ_PORTS-1:0]  rd_req [BANKS];
    logic [READ_PORTS-1:0]  rd_gnt [BANKS];
    logic [WRITE_PORTS-1:0] wr_req [BANKS];
    logic [WRITE_PORTS-1:0] wr_gnt [BANKS];

    logic                  wr_en  [BANKS];
    logic [ROW_WIDTH-1:0]  wr_row [BANKS];
    logic [DATA_WIDTH-1:0] wr_dat [BANKS];

    logic [DATA_WIDTH-1:0] mem [BANKS][ROWS];

    logic [CNT_WIDTH:0] inc;
    logic [CNT_WIDTH:0] cnt_sum;

    // Route each valid request to its bank; nothing requests while in reset.
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            rd_req[b] = '0;
            wr_req[b] = '0;
        end
        for (int p = 0; p < READ_PORTS; p++)
            rd_req[bank_of(r_addr[p])][p] = r_avalid[p] & rst;
        for (int p = 0; p < WRITE_PORTS; p++)
            wr_req[bank_of(w_addr[p])][p] = w_valid[p] & rst;
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        multibank_memory_rr_arb #(.N(READ_PORTS)) u_rd_arb (
            .clk (clk),
            .rst (rst),
            .req (rd_req[b]),
            .gnt (rd_gnt[b])
        );
        multibank_memory_rr_arb #(.N(WRITE_PORTS)) u_wr_arb (
            .clk (clk),
            .rst (rst),
            .req (wr_req[b]),
            .gnt (wr_gnt[b])
        );
    end

    // A port is ready when its own bank's arbiter granted it.
    always_comb begin
        for (int p = 0; p < READ_PORTS; p++)
            r_aready[p] = rd_gnt[bank_of(r_addr[p])][p];
        for (int p = 0; p < WRITE_PORTS; p++)
            w_ready[p] = wr_gnt[bank_of(w_addr[p])][p];
    end

    // Collapse the single granted write of each bank into an enable/row/data.
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            wr_en[b]  = 1'b0;
            wr_row[b] = '0;
            wr_dat[b] = '0;
        end
        for (int p = 0; p < WRITE_PORTS; p++) begin
            if (w_ready[p]) begin
                wr_en[bank_of(w_addr[p])]  = 1'b1;
                wr_row[bank_of(w_addr[p])] = row_of(w_addr[p]);
                wr_dat[bank_of(w_addr[p])] = w_data[p];
            end
        end
    end

    // Storage write port per bank.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; clearing it would cost a reset network for no functional gain.
        for (int b = 0; b < BANKS; b++)
            if (wr_en[b]) mem[b][wr_row[b]] <= wr_dat[b];
    end

    // Registered read data; sampling the old array value gives read-before-write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dvalid <= '0;
            r_data   <= '0;
        end else begin
            r_dvalid <= r_aready;
            for (int p = 0; p < READ_PORTS; p++)
                if (r_aready[p]) r_data[p] <= mem[bank_of(r_addr[p])][row_of(r_addr[p])];
        end
    end

    // Number of stalled requests this cycle and the unsaturated next count.
    always_comb begin
        inc = '0;
        for (int p = 0; p < READ_PORTS; p++)
            inc = inc + (CNT_WIDTH+1)'(r_avalid[p] && !r_aready[p]);
        for (int p = 0; p < WRITE_PORTS; p++)
            inc = inc + (CNT_WIDTH+1)'(w_valid[p] && !w_ready[p]);
        cnt_sum = {1'b0, conflict_cnt} + inc;
    end

    // Saturating conflict counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  conflict_cnt <= '0;
        else if (cnt_clr)          conflict_cnt <= '0;
        else if (cnt_sum[CNT_WIDTH]) conflict_cnt <= '1;
        else                       conflict_cnt <= cnt_sum[CNT_WIDTH-1:0];
    end
endmodule

// File: tb/tb_multibank_memory_rr.sv
// Directed bench for multibank_memory_rr: a low-interleaved instance with the
// default counter and a high-interleaved instance with a 4-bit counter, both
// driven by the same stimulus.
module tb_multibank_memory_rr;
    logic            clk = 1'b0;
    logic            rst;
    logic [2:0][5:0]  r_addr;
    logic [2:0]       r_avalid;
    logic [2:0][5:0]  w_addr;
    logic [2:0][31:0] w_data;
    logic [2:0]       w_valid;
    logic             cnt_clr;

    logic [2:0]       i1_r_aready, i1_r_dvalid, i1_w_ready;
    logic [2:0][31:0] i1_r_data;
    logic [15:0]      i1_cnt;
    logic [2:0]       i0_r_aready, i0_r_dvalid, i0_w_ready;
    logic [2:0][31:0] i0_r_data;
    logic [3:0]       i0_cnt;

    int vectors     = 0;
    int miscompares = 0;

    multibank_memory_rr u_dut_il1 (
        .clk          (clk),
        .rst          (rst),
        .r_addr       (r_addr),
        .r_avalid     (r_avalid),
        .r_aready     (i1_r_aready),
        .r_dvalid     (i1_r_dvalid),
        .r_data       (i1_r_data),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .w_valid      (w_valid),
        .w_ready      (i1_w_ready),
        .conflict_cnt (i1_cnt),
        .cnt_clr      (cnt_clr)
    );

    multibank_memory_rr #(.INTERLEAVE(0), .CNT_WIDTH(4)) u_dut_il0 (
        .clk          (clk),
        .rst          (rst),
        .r_addr       (r_addr),
        .r_avalid     (r_avalid),
        .r_aready     (i0_r_aready),
        .r_dvalid     (i0_r_dvalid),
        .r_data       (i0_r_data),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .w_valid      (w_valid),
        .w_ready      (i0_w_ready),
        .conflict_cnt (i0_cnt),
        .cnt_clr      (cnt_clr)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every read port requesting.
        rst = 1'b0; cnt_clr = 1'b0;
        r_addr = '0; r_avalid = 3'b111;
        w_addr = '0; w_data = '0; w_valid = 3'b000;
        repeat (2) tick();
        check("rst_r_aready", i1_r_aready, 3'b000);
        check("rst_r_aready_il0", i0_r_aready, 3'b000);
        check("rst_w_ready", i1_w_ready, 3'b000);
        check("rst_r_dvalid", i1_r_dvalid, 3'b000);
        for (int p = 0; p < 3; p++) check("rst_r_data", i1_r_data[p], 32'h0);
        check("rst_cnt", i1_cnt, 16'd0);
        check("rst_cnt_il0", i0_cnt, 4'd0);

        // Three writes to distinct banks in one cycle.
        rst = 1'b1; r_avalid = 3'b000;
        w_addr = {6'd2, 6'd1, 6'd0};
        w_data = {32'hA2, 32'hA1, 32'hA0};
        w_valid = 3'b111;
        #1 check("par_w_ready", i1_w_ready, 3'b111);
        tick();
        w_addr[0] = 6'd3; w_data[0] = 32'hA3; w_valid = 3'b001;
        r_addr = {6'd2, 6'd1, 6'd0}; r_avalid = 3'b111;
        #1 check("par_r_aready", i1_r_aready, 3'b111);
        check("par_w_ready2", i1_w_ready, 3'b001);
        tick();
        check("par_r_dvalid", i1_r_dvalid, 3'b111);
        check("rd_a0", i1_r_data[0], 32'hA0);
        check("rd_a1", i1_r_data[1], 32'hA1);
        check("rd_a2", i1_r_data[2], 32'hA2);
        w_valid = 3'b000; r_addr[0] = 6'd3; r_avalid = 3'b001;
        #1 check("rd3_aready", i1_r_aready, 3'b001);
        tick();
        check("rd3_dvalid", i1_r_dvalid, 3'b001);
        check("rd_a3", i1_r_data[0], 32'hA3);
        check("hold_data1", i1_r_data[1], 32'hA1);
        check("no_conflict_cnt", i1_cnt, 16'd0);

        // Seed addr 5 and addr 8 (different banks when low-interleaved).
        r_avalid = 3'b000;
        w_addr[0] = 6'd5; w_data[0] = 32'h77;
        w_addr[1] = 6'd8; w_data[1] = 32'h11;
        w_valid = 3'b011;
        #1 check("seed_w_ready", i1_w_ready, 3'b011);
        tick();
        w_valid = 3'b000;

        // Reset pulse so every arbiter pointer starts from zero.
        rst = 1'b0;
        tick();
        rst = 1'b1;

        // All three read ports hit addr 5; granted ports drop their request.
        r_addr = {6'd5, 6'd5, 6'd5}; r_avalid = 3'b111;
        #1 check("rr_gnt0", i1_r_aready, 3'b001);
        tick();
        check("rr_dv0", i1_r_dvalid, 3'b001);
        check("rr_data0", i1_r_data[0], 32'h77);
        check("rr_cnt0", i1_cnt, 16'd2);
        r_avalid = 3'b110;
        #1 check("rr_gnt1", i1_r_aready, 3'b010);
        tick();
        check("rr_dv1", i1_r_dvalid, 3'b010);
        check("rr_data1", i1_r_data[1], 32'h77);
        check("rr_cnt1", i1_cnt, 16'd3);
        r_avalid = 3'b100;
        #1 check("rr_gnt2", i1_r_aready, 3'b100);
        tick();
        check("rr_dv2", i1_r_dvalid, 3'b100);
        check("rr_data2", i1_r_data[2], 32'h77);
        check("rr_cnt2", i1_cnt, 16'd3);
        r_avalid = 3'b000;

        // Read and write addr 8 together: old data first, new data next.
        w_addr[0] = 6'd8; w_data[0] = 32'h55; w_valid = 3'b001;
        r_addr[0] = 6'd8; r_avalid = 3'b001;
        #1 check("rbw_aready", i1_r_aready, 3'b001);
        check("rbw_w_ready", i1_w_ready, 3'b001);
        tick();
        check("rbw_old", i1_r_data[0], 32'h11);
        w_valid = 3'b000;
        tick();
        check("rbw_new", i1_r_data[0], 32'h55);
        check("rbw_cnt", i1_cnt, 16'd3);
        r_avalid = 3'b000;

        // High interleave: addrs 0 and 1 share bank 0 (read pointer is at 1).
        r_addr[0] = 6'd0; r_addr[1] = 6'd1; r_avalid = 3'b011;
        #1 check("il0_same_bank", i0_r_aready, 3'b010);
        check("il1_diff_bank", i1_r_aready, 3'b011);
        tick();
        check("il0_dv_first", i0_r_dvalid, 3'b010);
        check("il0_cnt_stall", i0_cnt, 4'd4);
        r_avalid = 3'b001;
        #1 check("il0_second", i0_r_aready, 3'b001);
        tick();
        check("il0_dv_second", i0_r_dvalid, 3'b001);
        check("il0_cnt_hold", i0_cnt, 4'd4);
        r_addr[1] = 6'd16; r_avalid = 3'b011;
        #1 check("il0_diff_bank", i0_r_aready, 3'b011);
        check("il1_same_bank", i1_r_aready, 3'b010);
        tick();
        r_avalid = 3'b000;

        // Clear, then sustain 4 conflicts per cycle until the 4-bit counter saturates.
        cnt_clr = 1'b1;
        tick();
        check("clr_il0", i0_cnt, 4'd0);
        check("clr_il1", i1_cnt, 16'd0);
        cnt_clr = 1'b0;
        r_addr = {6'd0, 6'd0, 6'd0}; r_avalid = 3'b111;
        w_addr = {6'd32, 6'd32, 6'd32}; w_data = {32'h3, 32'h2, 32'h1}; w_valid = 3'b111;
        repeat (3) tick();
        check("sat_pre", i0_cnt, 4'd12);
        tick();
        check("sat_hit", i0_cnt, 4'hF);
        repeat (2) tick();
        check("sat_hold", i0_cnt, 4'hF);
        check("nosat_il1", i1_cnt, 16'd24);
        cnt_clr = 1'b1;
        tick();
        check("clr_prio_il0", i0_cnt, 4'd0);
        check("clr_prio_il1", i1_cnt, 16'd0);
        cnt_clr = 1'b0;

        // Park pointers at 1, then reset mid-cycle and confirm port 0 wins again.
        r_avalid = 3'b001; w_valid = 3'b001;
        tick();
        r_avalid = 3'b111; w_valid = 3'b111;
        #1 check("pre_rst_rd", i0_r_aready, 3'b010);
        check("pre_rst_wr", i0_w_ready, 3'b010);
        #1 rst = 1'b0;
        #1 check("mid_rst_rd", i0_r_aready, 3'b000);
        check("mid_rst_wr", i0_w_ready, 3'b000);
        check("mid_rst_cnt", i0_cnt, 4'd0);
        tick();
        check("rst_no_dvalid", i0_r_dvalid, 3'b000);
        rst = 1'b1;
        #1 check("post_rst_rd", i0_r_aready, 3'b001);
        check("post_rst_wr", i0_w_ready, 3'b001);
        check("post_rst_rd_il1", i1_r_aready, 3'b001);
        tick();
        r_avalid = 3'b000; w_valid = 3'b000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
